// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for a VGA-style display.
// Produces pixel coordinates, active-video flag, active-low syncs, a
// free-running frame counter and a divided, pausable animation strobe.
// active/hsync/vsync are registered from the next-cycle coordinates so they
// line up with x/y in the same cycle (zero skew).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       next_frame,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_EVT    = 10'(V_ACTIVE);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_next_frame;
  logic [7:0]  r_frame_count;
  logic [7:0]  r_div;

  logic        w_x_last;
  logic        w_y_last;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic [10:0] w_xe;
  logic [10:0] w_ye;
  logic        w_frame_evt;

  // Next-coordinate computation shared by the counters and the aligned flags
  always_comb begin
    w_x_last    = (r_x == H_LAST);
    w_y_last    = (r_y == V_LAST);
    w_x_nxt     = w_x_last ? 10'd0 : r_x + 10'd1;
    w_y_nxt     = r_y;
    if (w_x_last) begin
      w_y_nxt = w_y_last ? 10'd0 : r_y + 10'd1;
    end
    w_xe        = {1'b0, w_x_nxt};
    w_ye        = {1'b0, w_y_nxt};
    w_frame_evt = (r_x == 10'd0) && (r_y == V_EVT);
  end

  // Raster counters and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_frame_count <= 8'd0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      if (w_x_last && w_y_last) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Active/sync flags registered from the next coordinates for zero skew
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b1;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_active <= (w_xe < H_ACT) && (w_ye < V_ACT);
      r_hsync  <= !((w_xe >= H_SS) && (w_xe < H_SE));
      r_vsync  <= !((w_ye >= V_SS) && (w_ye < V_SE));
    end
  end

  // Frame divider: pulse the cycle after a qualifying frame event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= 8'd0;
      r_next_frame <= 1'b0;
    end else begin
      r_next_frame <= 1'b0;
      if (w_frame_evt && !pause) begin
        if (r_div == DIV_LAST) begin
          r_div        <= 8'd0;
          r_next_frame <= 1'b1;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign next_frame  = r_next_frame;
  assign frame_count = r_frame_count;

endmodule
